// File: rtl/instr_realign_seq_if.sv
// Bundles the fetch-side and decoder-side handshakes of the instruction
// realignment sequencer. The sequencer uses the slave modport; the fetch
// unit and decoder environment use the master modport.
interface instr_realign_seq_if #(
  parameter int unsigned PC_WIDTH = 64
);
  // fetch side
  logic                fetch_valid_i;
  logic                fetch_ready_o;
  logic [PC_WIDTH-1:0] fetch_addr_i;
  logic [31:0]         fetch_data_i;
  // redirect
  logic                flush_i;
  logic [PC_WIDTH-1:0] flush_pc_i;
  // decoder side
  logic                dec_valid_o;
  logic                dec_ready_i;
  logic [31:0]         dec_instr_o;
  logic [PC_WIDTH-1:0] dec_pc_o;
  logic                dec_is_compressed_o;
  logic [15:0]         dec_compressed_instr_o;

  modport slave (
    input  fetch_valid_i, fetch_addr_i, fetch_data_i,
    input  flush_i, flush_pc_i,
    input  dec_ready_i,
    output fetch_ready_o,
    output dec_valid_o, dec_instr_o, dec_pc_o,
    output dec_is_compressed_o, dec_compressed_instr_o
  );

  modport master (
    output fetch_valid_i, fetch_addr_i, fetch_data_i,
    output flush_i, flush_pc_i,
    output dec_ready_i,
    input  fetch_ready_o,
    input  dec_valid_o, dec_instr_o, dec_pc_o,
    input  dec_is_compressed_o, dec_compressed_instr_o
  );
endinterface

// File: rtl/instr_realign_seq.sv
// Instruction realignment sequencer: turns 32-bit aligned fetch words into
// one instruction per decoder handshake, handling RVC parcels, 32-bit
// instructions straddling two fetch words, and redirect flushes.
//
// Selection cases (evaluated every cycle from registers, first match wins):
//   sel          | meaning
//   SEL_NONE     | nothing to present
//   SEL_JOIN     | pending upper half + lower parcel of new word form one 32-bit instr
//   SEL_LO_C     | lower parcel is compressed
//   SEL_FULL     | lower parcel starts an aligned 32-bit instr (whole word)
//   SEL_HI_C     | upper parcel is compressed
//   SEL_STRADDLE | upper parcel starts a 32-bit instr; park it as a half (one bubble)
module instr_realign_seq #(
  parameter int unsigned PC_WIDTH = 64
) (
  input logic                clk_i,
  input logic                rst_i,
  instr_realign_seq_if.slave bus
);

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_JOIN,
    SEL_LO_C,
    SEL_FULL,
    SEL_HI_C,
    SEL_STRADDLE
  } sel_e;

  localparam logic [PC_WIDTH-1:0] PARCEL_BYTES = PC_WIDTH'(2);

  // buffered fetch word
  logic [31:0]         word_q;
  logic [PC_WIDTH-1:0] word_addr_q;
  logic                word_vld_q;
  logic                offset_q;
  // upper parcel of a straddling instruction
  logic [15:0]         half_q;
  logic [PC_WIDTH-1:0] half_pc_q;
  logic                half_vld_q;
  // start parcel for the first word after a redirect
  logic                start_off_q;

  sel_e                sel;
  logic                has_instr;
  logic [31:0]         instr;
  logic [PC_WIDTH-1:0] pc;
  logic                is_c;
  logic [15:0]         c_instr;
  logic                consume;
  logic                word_empty;
  logic                fetch_ready;
  logic                accept;
  logic                unused_bits;

  function automatic logic is_rvc(input logic [15:0] parcel);
    return parcel[1:0] != 2'b11;
  endfunction

  // pick which parcel(s) form the instruction presented this cycle
  always_comb begin
    sel = SEL_NONE;
    if (half_vld_q && word_vld_q) begin
      sel = SEL_JOIN;
    end else if (word_vld_q && !offset_q) begin
      sel = is_rvc(word_q[15:0]) ? SEL_LO_C : SEL_FULL;
    end else if (word_vld_q && offset_q) begin
      sel = is_rvc(word_q[31:16]) ? SEL_HI_C : SEL_STRADDLE;
    end
  end

  // build the decoder payload for the selected case
  always_comb begin
    has_instr = 1'b0;
    instr     = '0;
    pc        = '0;
    is_c      = 1'b0;
    c_instr   = '0;
    unique case (sel)
      SEL_JOIN: begin
        has_instr = 1'b1;
        instr     = {word_q[15:0], half_q};
        pc        = half_pc_q;
      end
      SEL_LO_C: begin
        has_instr = 1'b1;
        instr     = {16'h0, word_q[15:0]};
        pc        = word_addr_q;
        is_c      = 1'b1;
        c_instr   = word_q[15:0];
      end
      SEL_FULL: begin
        has_instr = 1'b1;
        instr     = word_q;
        pc        = word_addr_q;
      end
      SEL_HI_C: begin
        has_instr = 1'b1;
        instr     = {16'h0, word_q[31:16]};
        pc        = word_addr_q + PARCEL_BYTES;
        is_c      = 1'b1;
        c_instr   = word_q[31:16];
      end
      default: begin
        has_instr = 1'b0;
      end
    endcase
  end

  // handshake qualification; a redirect voids both handshakes this cycle
  always_comb begin
    consume     = has_instr && !bus.flush_i && bus.dec_ready_i;
    word_empty  = (consume && (sel == SEL_FULL || sel == SEL_HI_C)) ||
                  (sel == SEL_STRADDLE);
    fetch_ready = !bus.flush_i && (!word_vld_q || word_empty);
    accept      = bus.fetch_valid_i && fetch_ready;
  end

  assign bus.dec_valid_o            = has_instr && !bus.flush_i;
  assign bus.dec_instr_o            = instr;
  assign bus.dec_pc_o               = pc;
  assign bus.dec_is_compressed_o    = is_c;
  assign bus.dec_compressed_instr_o = c_instr;
  assign bus.fetch_ready_o          = fetch_ready;

  // address alignment bits and the redirect target above bit 1 are not needed
  assign unused_bits = ^{bus.fetch_addr_i[1:0], bus.flush_pc_i[PC_WIDTH-1:2],
                         bus.flush_pc_i[0]};

  // word buffer: consume advances the parcel pointer, a new word overrides it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q      <= '0;
      word_addr_q <= '0;
      word_vld_q  <= 1'b0;
      offset_q    <= 1'b0;
      start_off_q <= 1'b0;
    end else if (bus.flush_i) begin
      word_vld_q  <= 1'b0;
      start_off_q <= bus.flush_pc_i[1];
    end else begin
      if (consume && (sel == SEL_JOIN || sel == SEL_LO_C)) begin
        offset_q <= 1'b1;
      end
      if (word_empty) begin
        word_vld_q <= 1'b0;
      end
      if (accept) begin
        word_q      <= bus.fetch_data_i;
        word_addr_q <= {bus.fetch_addr_i[PC_WIDTH-1:2], 2'b00};
        word_vld_q  <= 1'b1;
        offset_q    <= start_off_q;
        start_off_q <= 1'b0;
      end
    end
  end

  // half buffer: park the upper parcel of a straddling instruction until joined
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      half_q     <= '0;
      half_pc_q  <= '0;
      half_vld_q <= 1'b0;
    end else if (bus.flush_i) begin
      half_vld_q <= 1'b0;
    end else if (sel == SEL_STRADDLE) begin
      half_q     <= word_q[31:16];
      half_pc_q  <= word_addr_q + PARCEL_BYTES;
      half_vld_q <= 1'b1;
    end else if (consume && sel == SEL_JOIN) begin
      half_vld_q <= 1'b0;
    end
  end

endmodule
